// File: rtl/axi_rd_pkg.sv
// ---------------------------------------------------------------------------
// axi_rd_pkg
// Shared definitions for the AXI read-data (R) channel router.
//   - AXI width constants (master-side ID, extended slave-side ID, data)
//   - rdr_state_e   : router FSM states
//   - S*_IDX/M*_IDX : slave and master port indices
//   - MIDX_MSB/LSB  : master-index field inside the extended slave-side ID
//   - TIMEOUT_DEFAULT : default idle-beat limit for the optional watchdog
// ---------------------------------------------------------------------------
package axi_rd_pkg;

    localparam int unsigned AXI_ID_BITS   = 4;
    localparam int unsigned AXI_IDS_BITS  = 8;
    localparam int unsigned AXI_DATA_BITS = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } rdr_state_e;

    localparam logic [2:0] S0_IDX = 3'd0;
    localparam logic [2:0] S1_IDX = 3'd1;
    localparam logic [2:0] S2_IDX = 3'd2;
    localparam logic [2:0] S3_IDX = 3'd3;
    localparam logic [2:0] S4_IDX = 3'd4;
    localparam logic [2:0] S5_IDX = 3'd5;

    localparam logic [1:0] M0_IDX = 2'd0;
    localparam logic [1:0] M1_IDX = 2'd1;
    localparam logic [1:0] M2_IDX = 2'd2;

    localparam int unsigned MIDX_MSB = 7;
    localparam int unsigned MIDX_LSB = 4;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_arbiter6.sv
// ---------------------------------------------------------------------------
// rr_arbiter6
// Combinational 6-request round-robin arbiter. The search starts at the
// slave after last_grant_i and wraps 5 -> 0, so the previous winner has the
// lowest priority.
// Ports:
//   req_i        [5:0] request vector (one bit per slave)
//   last_grant_i [2:0] index of the previously granted slave (0..5)
//   gnt_idx_o    [2:0] encoded index of the winning request
//   gnt_valid_o        at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter6 (
    input  logic [5:0] req_i,
    input  logic [2:0] last_grant_i,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o
);

    always_comb begin
        logic [2:0] idx;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= 6; k++) begin
            idx = 3'((32'(last_grant_i) + k) % 6);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_idx_o   = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_data_router.sv
// ---------------------------------------------------------------------------
// read_data_router
// AXI R-channel router: collects read-data beats from six slaves
// (S0 ROM, S1 IM, S2 DM, S3 DMA, S4 WDT, S5 DRAM) and forwards each burst to
// master M0..M2 selected by RID_Sx[7:4]. A slave keeps the grant for a whole
// burst; bursts are arbitrated round-robin. Beats whose master index is not
// 0..2 are sunk and dec_err pulses on the completing beat.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   R*_S0..R*_S5             slave-side R channel (RREADY_Sx is an output)
//   R*_M0..R*_M2             master-side R channel (RREADY_Mx is an input)
//   dec_err                  one-cycle pulse on a sunk/aborted burst end
// Build option:
//   RDR_TIMEOUT_EN  when defined, a stalled locked burst is abandoned after
//                   TIMEOUT cycles without a handshake (dec_err pulses).
// ---------------------------------------------------------------------------
module read_data_router
    import axi_rd_pkg::*;
#(
    parameter int unsigned NUM_S   = 6,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [AXI_IDS_BITS-1:0]  RID_S0,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S0,
    input  logic [1:0]               RRESP_S0,
    input  logic                     RLAST_S0,
    input  logic                     RVALID_S0,
    output logic                     RREADY_S0,

    input  logic [AXI_IDS_BITS-1:0]  RID_S1,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S1,
    input  logic [1:0]               RRESP_S1,
    input  logic                     RLAST_S1,
    input  logic                     RVALID_S1,
    output logic                     RREADY_S1,

    input  logic [AXI_IDS_BITS-1:0]  RID_S2,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S2,
    input  logic [1:0]               RRESP_S2,
    input  logic                     RLAST_S2,
    input  logic                     RVALID_S2,
    output logic                     RREADY_S2,

    input  logic [AXI_IDS_BITS-1:0]  RID_S3,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S3,
    input  logic [1:0]               RRESP_S3,
    input  logic                     RLAST_S3,
    input  logic                     RVALID_S3,
    output logic                     RREADY_S3,

    input  logic [AXI_IDS_BITS-1:0]  RID_S4,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S4,
    input  logic [1:0]               RRESP_S4,
    input  logic                     RLAST_S4,
    input  logic                     RVALID_S4,
    output logic                     RREADY_S4,

    input  logic [AXI_IDS_BITS-1:0]  RID_S5,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S5,
    input  logic [1:0]               RRESP_S5,
    input  logic                     RLAST_S5,
    input  logic                     RVALID_S5,
    output logic                     RREADY_S5,

    output logic [AXI_ID_BITS-1:0]   RID_M0,
    output logic [AXI_DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]               RRESP_M0,
    output logic                     RLAST_M0,
    output logic                     RVALID_M0,
    input  logic                     RREADY_M0,

    output logic [AXI_ID_BITS-1:0]   RID_M1,
    output logic [AXI_DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]               RRESP_M1,
    output logic                     RLAST_M1,
    output logic                     RVALID_M1,
    input  logic                     RREADY_M1,

    output logic [AXI_ID_BITS-1:0]   RID_M2,
    output logic [AXI_DATA_BITS-1:0] RDATA_M2,
    output logic [1:0]               RRESP_M2,
    output logic                     RLAST_M2,
    output logic                     RVALID_M2,
    input  logic                     RREADY_M2,

    output logic                     dec_err
);

    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
        $error("read_data_router: TIMEOUT must be in 1..255");
    end

    // ---------------- slave / master port bundling ----------------
    logic [NUM_S-1:0]         s_valid, s_last, s_ready;
    logic [AXI_IDS_BITS-1:0]  s_id   [6];
    logic [AXI_DATA_BITS-1:0] s_data [6];
    logic [1:0]               s_resp [6];

    logic [2:0]               m_valid, m_last, m_ready;
    logic [AXI_ID_BITS-1:0]   m_id   [3];
    logic [AXI_DATA_BITS-1:0] m_data [3];
    logic [1:0]               m_resp [3];

    assign s_valid = {RVALID_S5, RVALID_S4, RVALID_S3, RVALID_S2, RVALID_S1, RVALID_S0};
    assign s_last  = {RLAST_S5,  RLAST_S4,  RLAST_S3,  RLAST_S2,  RLAST_S1,  RLAST_S0};
    assign m_ready = {RREADY_M2, RREADY_M1, RREADY_M0};

    assign s_id[S0_IDX] = RID_S0;   assign s_data[S0_IDX] = RDATA_S0;   assign s_resp[S0_IDX] = RRESP_S0;
    assign s_id[S1_IDX] = RID_S1;   assign s_data[S1_IDX] = RDATA_S1;   assign s_resp[S1_IDX] = RRESP_S1;
    assign s_id[S2_IDX] = RID_S2;   assign s_data[S2_IDX] = RDATA_S2;   assign s_resp[S2_IDX] = RRESP_S2;
    assign s_id[S3_IDX] = RID_S3;   assign s_data[S3_IDX] = RDATA_S3;   assign s_resp[S3_IDX] = RRESP_S3;
    assign s_id[S4_IDX] = RID_S4;   assign s_data[S4_IDX] = RDATA_S4;   assign s_resp[S4_IDX] = RRESP_S4;
    assign s_id[S5_IDX] = RID_S5;   assign s_data[S5_IDX] = RDATA_S5;   assign s_resp[S5_IDX] = RRESP_S5;

    assign {RREADY_S5, RREADY_S4, RREADY_S3, RREADY_S2, RREADY_S1, RREADY_S0} = s_ready;

    assign RVALID_M0 = m_valid[M0_IDX];  assign RLAST_M0 = m_last[M0_IDX];
    assign RID_M0    = m_id[M0_IDX];     assign RDATA_M0 = m_data[M0_IDX];  assign RRESP_M0 = m_resp[M0_IDX];
    assign RVALID_M1 = m_valid[M1_IDX];  assign RLAST_M1 = m_last[M1_IDX];
    assign RID_M1    = m_id[M1_IDX];     assign RDATA_M1 = m_data[M1_IDX];  assign RRESP_M1 = m_resp[M1_IDX];
    assign RVALID_M2 = m_valid[M2_IDX];  assign RLAST_M2 = m_last[M2_IDX];
    assign RID_M2    = m_id[M2_IDX];     assign RDATA_M2 = m_data[M2_IDX];  assign RRESP_M2 = m_resp[M2_IDX];

    // ---------------- state ----------------
    rdr_state_e state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_grant_q, last_grant_d;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [3:0] dest;
    logic       dest_ok;
    logic       hs;
    logic       done;

`ifdef RDR_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       expire;
`endif

    rr_arbiter6 u_arb (
        .req_i        (s_valid),
        .last_grant_i (last_grant_q),
        .gnt_idx_o    (gnt_idx),
        .gnt_valid_o  (gnt_valid)
    );

    // Locked pass-through: only the destination master sees the burst,
    // only the selected slave sees a ready.
    always_comb begin
        m_valid = '0;
        m_last  = '0;
        s_ready = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            m_id[i]   = '0;
            m_data[i] = '0;
            m_resp[i] = '0;
        end

        dest    = s_id[sel_q][MIDX_MSB:MIDX_LSB];
        dest_ok = (dest <= 4'(M2_IDX));

        if (state_q == LOCKED) begin
            if (dest_ok) begin
                m_valid[dest[1:0]] = s_valid[sel_q];
                m_last[dest[1:0]]  = s_last[sel_q];
                m_id[dest[1:0]]    = s_id[sel_q][AXI_ID_BITS-1:0];
                m_data[dest[1:0]]  = s_data[sel_q];
                m_resp[dest[1:0]]  = s_resp[sel_q];
                s_ready[sel_q]     = m_ready[dest[1:0]];
            end else begin
                s_ready[sel_q] = 1'b1;
            end
        end

        hs      = (state_q == LOCKED) && s_valid[sel_q] && s_ready[sel_q];
        done    = hs && s_last[sel_q];
        dec_err = done && !dest_ok;

        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
`ifdef RDR_TIMEOUT_EN
        cnt_d  = cnt_q;
        expire = (state_q == LOCKED) && !hs && (cnt_q == 8'(TIMEOUT - 1));
        if (expire) dec_err = 1'b1;
`endif

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    sel_d   = gnt_idx;
                    state_d = LOCKED;
`ifdef RDR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            LOCKED: begin
                if (done) begin
                    state_d      = IDLE;
                    last_grant_d = sel_q;
                end
`ifdef RDR_TIMEOUT_EN
                else if (hs) begin
                    cnt_d = '0;
                end else if (expire) begin
                    state_d      = IDLE;
                    last_grant_d = sel_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sel_q        <= S0_IDX;
            last_grant_q <= S5_IDX;
`ifdef RDR_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
`ifdef RDR_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_read_data_router.sv
// ---------------------------------------------------------------------------
// tb_read_data_router
// Directed bench for read_data_router: reset, single burst, round-robin
// arbitration, master backpressure, undecodable master index, and the
// stalled-burst behaviour (watchdog when RDR_TIMEOUT_EN is defined, grant
// held otherwise). DUT is built with TIMEOUT = 8.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_read_data_router;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  rid_s   [6];
    logic [31:0] rdata_s [6];
    logic [1:0]  rresp_s [6];
    logic [5:0]  rlast_s, rvalid_s;
    wire  [5:0]  rready_s;

    wire  [3:0]  rid_m   [3];
    wire  [31:0] rdata_m [3];
    wire  [1:0]  rresp_m [3];
    wire  [2:0]  rlast_m, rvalid_m;
    logic [2:0]  rready_m;
    wire         dec_err;

    int n_tests = 0;
    int n_fail  = 0;
    int mhs;

    read_data_router #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .RID_S0(rid_s[0]), .RDATA_S0(rdata_s[0]), .RRESP_S0(rresp_s[0]), .RLAST_S0(rlast_s[0]), .RVALID_S0(rvalid_s[0]), .RREADY_S0(rready_s[0]),
        .RID_S1(rid_s[1]), .RDATA_S1(rdata_s[1]), .RRESP_S1(rresp_s[1]), .RLAST_S1(rlast_s[1]), .RVALID_S1(rvalid_s[1]), .RREADY_S1(rready_s[1]),
        .RID_S2(rid_s[2]), .RDATA_S2(rdata_s[2]), .RRESP_S2(rresp_s[2]), .RLAST_S2(rlast_s[2]), .RVALID_S2(rvalid_s[2]), .RREADY_S2(rready_s[2]),
        .RID_S3(rid_s[3]), .RDATA_S3(rdata_s[3]), .RRESP_S3(rresp_s[3]), .RLAST_S3(rlast_s[3]), .RVALID_S3(rvalid_s[3]), .RREADY_S3(rready_s[3]),
        .RID_S4(rid_s[4]), .RDATA_S4(rdata_s[4]), .RRESP_S4(rresp_s[4]), .RLAST_S4(rlast_s[4]), .RVALID_S4(rvalid_s[4]), .RREADY_S4(rready_s[4]),
        .RID_S5(rid_s[5]), .RDATA_S5(rdata_s[5]), .RRESP_S5(rresp_s[5]), .RLAST_S5(rlast_s[5]), .RVALID_S5(rvalid_s[5]), .RREADY_S5(rready_s[5]),
        .RID_M0(rid_m[0]), .RDATA_M0(rdata_m[0]), .RRESP_M0(rresp_m[0]), .RLAST_M0(rlast_m[0]), .RVALID_M0(rvalid_m[0]), .RREADY_M0(rready_m[0]),
        .RID_M1(rid_m[1]), .RDATA_M1(rdata_m[1]), .RRESP_M1(rresp_m[1]), .RLAST_M1(rlast_m[1]), .RVALID_M1(rvalid_m[1]), .RREADY_M1(rready_m[1]),
        .RID_M2(rid_m[2]), .RDATA_M2(rdata_m[2]), .RRESP_M2(rresp_m[2]), .RLAST_M2(rlast_m[2]), .RVALID_M2(rvalid_m[2]), .RREADY_M2(rready_m[2]),
        .dec_err(dec_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Drives an n-beat burst from slave s, assuming s already holds the
    // grant and the destination master is ready; checks every beat at m.
    task automatic burst(input int s, input int m, input logic [7:0] id,
                         input logic [31:0] base, input int n, input string tag);
        logic [2:0] em;
        logic [5:0] es;
        em = '0; em[m] = 1'b1;
        es = '0; es[s] = 1'b1;
        for (int b = 0; b < n; b++) begin
            rid_s[s]    = id;
            rdata_s[s]  = base + 32'(b);
            rresp_s[s]  = 2'(b);
            rlast_s[s]  = (b == n - 1);
            rvalid_s[s] = 1'b1;
            settle();
            chk($sformatf("%s_valid_b%0d", tag, b), 32'(rvalid_m), 32'(em));
            chk($sformatf("%s_ready_b%0d", tag, b), 32'(rready_s), 32'(es));
            chk($sformatf("%s_id_b%0d",    tag, b), 32'(rid_m[m]), 32'(id[3:0]));
            chk($sformatf("%s_data_b%0d",  tag, b), rdata_m[m], base + 32'(b));
            chk($sformatf("%s_resp_b%0d",  tag, b), 32'(rresp_m[m]), 32'(b[1:0]));
            chk($sformatf("%s_last_b%0d",  tag, b), 32'(rlast_m[m]), 32'(b == n - 1));
            chk($sformatf("%s_other_b%0d", tag, b), rdata_m[(m + 1) % 3], 32'h0);
            tick();
        end
    endtask

    initial begin
        rst      = 1'b0;
        rvalid_s = '0;
        rlast_s  = '0;
        rready_m = 3'b111;
        for (int i = 0; i < 6; i++) begin
            rid_s[i] = '0; rdata_s[i] = '0; rresp_s[i] = '0;
        end

        // ---- reset with S2 requesting ----
        rid_s[2] = 8'h03; rdata_s[2] = 32'h55; rlast_s[2] = 1'b1; rvalid_s[2] = 1'b1;
        tick(); tick();
        chk("rst_rvalid_m", 32'(rvalid_m), 32'h0);
        chk("rst_rready_s", 32'(rready_s), 32'h0);
        chk("rst_dec_err",  32'(dec_err),  32'h0);
        rst = 1'b1;
        settle();
        chk("rel_no_grant_yet", 32'(rvalid_m), 32'h0);
        tick();
        chk("rel_rvalid_m0", 32'(rvalid_m), 32'h1);
        chk("rel_rid_m0",    32'(rid_m[0]), 32'h3);
        chk("rel_rdata_m0",  rdata_m[0], 32'h55);
        chk("rel_rready_s2", 32'(rready_s), 32'h04);
        tick();
        rvalid_s[2] = 1'b0;
        settle();
        chk("rel_idle", 32'(rvalid_m), 32'h0);

        // ---- single 4-beat burst S1 -> M1 ----
        rid_s[1] = 8'h12; rdata_s[1] = 32'hA0; rlast_s[1] = 1'b0; rvalid_s[1] = 1'b1;
        settle();
        chk("s1_idle_latency", 32'(rvalid_m), 32'h0);
        tick();
        burst(1, 1, 8'h12, 32'hA0, 4, "s1");
        rvalid_s[1] = 1'b0;
        settle();
        chk("s1_after_valid", 32'(rvalid_m), 32'h0);
        chk("s1_after_ready", 32'(rready_s), 32'h0);

        // ---- arbitration: make S0 last_grant, then S0 and S2 together ----
        rid_s[0] = 8'h00; rlast_s[0] = 1'b1; rvalid_s[0] = 1'b1;
        settle();
        tick();
        burst(0, 0, 8'h00, 32'h10, 1, "s0pre");
        rvalid_s[0] = 1'b0;
        rid_s[0] = 8'h01; rdata_s[0] = 32'hB0; rlast_s[0] = 1'b0; rvalid_s[0] = 1'b1;
        rid_s[2] = 8'h24; rdata_s[2] = 32'hD0; rlast_s[2] = 1'b0; rvalid_s[2] = 1'b1;
        settle();
        chk("arb_idle", 32'(rvalid_m), 32'h0);
        tick();
        burst(2, 2, 8'h24, 32'hD0, 2, "arb_s2");
        rvalid_s[2] = 1'b0;
        settle();
        chk("arb_gap_valid", 32'(rvalid_m), 32'h0);
        chk("arb_gap_ready", 32'(rready_s), 32'h0);
        tick();
        burst(0, 0, 8'h01, 32'hB0, 2, "arb_s0");
        rvalid_s[0] = 1'b0;

        // ---- backpressure: S5 -> M0, M0 stalls 3 cycles on beat 1 ----
        rid_s[5] = 8'h07; rdata_s[5] = 32'hC0; rlast_s[5] = 1'b0; rvalid_s[5] = 1'b1;
        settle();
        tick();
        mhs = 0;
        for (int b = 0; b < 4; b++) begin
            rdata_s[5]  = 32'hC0 + 32'(b);
            rlast_s[5]  = (b == 3);
            rvalid_s[5] = 1'b1;
            if (b == 1) begin
                rready_m[0] = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    settle();
                    chk($sformatf("bp_rready_s5_c%0d", c), 32'(rready_s), 32'h0);
                    chk($sformatf("bp_hold_data_c%0d", c), rdata_m[0], 32'hC1);
                    chk($sformatf("bp_hold_valid_c%0d", c), 32'(rvalid_m), 32'h1);
                    tick();
                end
                rready_m[0] = 1'b1;
            end
            if (b == 2) begin
                rvalid_s[5] = 1'b0;
                settle();
                chk("bp_slave_gap", 32'(rvalid_m), 32'h0);
                tick();
                rvalid_s[5] = 1'b1;
            end
            settle();
            chk($sformatf("bp_data_b%0d", b), rdata_m[0], 32'hC0 + 32'(b));
            chk($sformatf("bp_valid_b%0d", b), 32'(rvalid_m), 32'h1);
            if (rvalid_m[0] && rready_m[0]) mhs++;
            tick();
        end
        chk("bp_beat_count", 32'(mhs), 32'd4);
        rvalid_s[5] = 1'b0;
        settle();
        chk("bp_idle", 32'(rvalid_m), 32'h0);

        // ---- undecodable master index: S3 RID=8'h52, sunk ----
        rready_m = '0;
        rid_s[3] = 8'h52; rdata_s[3] = 32'hE0; rlast_s[3] = 1'b0; rvalid_s[3] = 1'b1;
        settle();
        tick();
        settle();
        chk("bad_ready_b0",  32'(rready_s), 32'h08);
        chk("bad_valid_b0",  32'(rvalid_m), 32'h0);
        chk("bad_decerr_b0", 32'(dec_err),  32'h0);
        tick();
        rdata_s[3] = 32'hE1; rlast_s[3] = 1'b1;
        settle();
        chk("bad_ready_b1",  32'(rready_s), 32'h08);
        chk("bad_valid_b1",  32'(rvalid_m), 32'h0);
        chk("bad_decerr_b1", 32'(dec_err),  32'h1);
        tick();
        rvalid_s[3] = 1'b0;
        settle();
        chk("bad_decerr_after", 32'(dec_err),  32'h0);
        chk("bad_ready_after",  32'(rready_s), 32'h0);
        rready_m = 3'b111;

        // ---- stalled burst from S4 with S5 pending ----
        rid_s[4] = 8'h00; rdata_s[4] = 32'hF0; rlast_s[4] = 1'b0; rvalid_s[4] = 1'b1;
        rid_s[5] = 8'h01; rdata_s[5] = 32'h99; rlast_s[5] = 1'b1; rvalid_s[5] = 1'b1;
        settle();
        tick();
        settle();
        chk("stall_grant_s4_valid", 32'(rvalid_m), 32'h1);
        chk("stall_grant_s4_ready", 32'(rready_s), 32'h10);
        tick();
        rvalid_s[4] = 1'b0;
`ifdef RDR_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk($sformatf("to_decerr_k%0d", k), 32'(dec_err), 32'(k == 8));
            chk($sformatf("to_ready_k%0d", k),  32'(rready_s), 32'h10);
            tick();
        end
        settle();
        chk("to_idle_valid",  32'(rvalid_m), 32'h0);
        chk("to_idle_decerr", 32'(dec_err),  32'h0);
        tick();
        burst(5, 0, 8'h01, 32'h99, 1, "to_s5");
        rvalid_s[5] = 1'b0;
`else
        for (int k = 0; k < 20; k++) begin
            settle();
            chk($sformatf("hold_ready_k%0d", k),  32'(rready_s), 32'h10);
            chk($sformatf("hold_valid_k%0d", k),  32'(rvalid_m), 32'h0);
            chk($sformatf("hold_decerr_k%0d", k), 32'(dec_err),  32'h0);
            tick();
        end
        burst(4, 0, 8'h00, 32'hF1, 1, "hold_s4");
        rvalid_s[4] = 1'b0;
        settle();
        chk("hold_idle_valid", 32'(rvalid_m), 32'h0);
        tick();
        burst(5, 0, 8'h01, 32'h99, 1, "hold_s5");
        rvalid_s[5] = 1'b0;
`endif
        settle();
        chk("end_idle", 32'(rvalid_m), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
